// File: rtl/rot_pkg.sv
// Shared types and helpers for the sequential rotate/shift engine.
//   mode_e  : operation select; bit 0 = direction (0 right, 1 left),
//             bit 1 = kind (0 rotate, 1 logical shift).
//   state_e : engine FSM states.
//   step_count(): number of single-position steps a job needs.
package rot_pkg;

  typedef enum logic [1:0] {
    ROTR = 2'b00,
    ROTL = 2'b01,
    SHR  = 2'b10,
    SHL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Rotates wrap, so only amount mod width matters (width is a power of two).
  // Shifts saturate at width: after width steps the word is all zeros anyway.
  function automatic int unsigned step_count(mode_e m, int unsigned amt,
                                             int unsigned width);
    if (!m[1]) return amt & (width - 1);
    else       return (amt >= width) ? width : amt;
  endfunction

endpackage

// File: rtl/rot_step.sv
// One-position rotate/shift of a WIDTH-bit word.
//   d_i    : input word
//   mode_i : operation (rot_pkg::mode_e)
//   d_o    : word moved by exactly one position
// Purely combinational.
module rot_step
  import rot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    case (mode_i)
      ROTR:    d_o = {d_i[0], d_i[WIDTH-1:1]};
      ROTL:    d_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
      SHR:     d_o = {1'b0, d_i[WIDTH-1:1]};
      SHL:     d_o = {d_i[WIDTH-2:0], 1'b0};
      default: d_o = d_i;
    endcase
  end

endmodule

// File: rtl/rot_shift_seq.sv
// Sequential rotate/shift engine, one bit position per clock.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   operand/mode/amount : request payload, sampled on the accept edge
//   out_valid/out_ready : response handshake (valid only in DONE)
//   result              : registered result, held while out_valid
//   busy                : job in RUN or DONE
module rot_shift_seq
  import rot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  // Remaining-step counter must hold WIDTH itself (saturated shifts).
  localparam int REM_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_out;
  logic [REM_W-1:0] n_in;

  assign n_in = REM_W'(step_count(mode_e'(mode), 32'(amount), WIDTH));

  rot_step #(.WIDTH(WIDTH)) u_step (
    .d_i    (data_q),
    .mode_i (mode_q),
    .d_o    (step_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = operand;
          mode_d  = mode_e'(mode);
          rem_d   = n_in;
          state_d = (n_in == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        data_d = step_out;
        rem_d  = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= ROTR;
      data_q      <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // data_q only moves in RUN, so it is stable for the whole DONE phase.
  assign result    = data_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rot_shift_seq.sv
// Randomised self-checking bench for rot_shift_seq. Two instances (WIDTH=8
// and WIDTH=4) share the request stream; the 4-bit one sees the low nibble.
module tb_rot_shift_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [7:0] operand;
  logic [1:0] mode;
  logic [3:0] amount;

  logic       ir8, ov8, bz8;
  logic [7:0] res8;
  logic       ir4, ov4, bz4;
  logic [3:0] res4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rot_shift_seq #(.WIDTH(8), .AMT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
    .operand(operand), .mode(mode), .amount(amount),
    .out_valid(ov8), .out_ready(out_ready), .result(res8), .busy(bz8)
  );

  rot_shift_seq #(.WIDTH(4), .AMT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .operand(operand[3:0]), .mode(mode), .amount(amount),
    .out_valid(ov4), .out_ready(out_ready), .result(res4), .busy(bz4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic on a w-bit value.
  function automatic int unsigned model(input int unsigned w, input int unsigned op,
                                        input int unsigned m, input int unsigned amt,
                                        output int unsigned n);
    int unsigned mask, x;
    mask = (1 << w) - 1;
    x    = op & mask;
    if (m < 2) n = amt % w;
    else       n = (amt >= w) ? w : amt;
    case (m)
      0:       return ((x >> n) | (x << (w - n))) & mask;
      1:       return ((x << n) | (x >> (w - n))) & mask;
      2:       return x >> n;
      default: return (x << n) & mask;
    endcase
  endfunction

  task automatic run_job(input logic [7:0] op, input logic [1:0] m, input logic [3:0] amt);
    int unsigned n8, n4, e8, e4;
    int lat8, lat4;
    e8 = model(8, op, m, amt, n8);
    e4 = model(4, op, m, amt, n4);
    @(negedge clk);
    operand = op; mode = m; amount = amt; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs: only the accept edge may matter.
    in_valid = 1'b0;
    operand = 8'($urandom); mode = 2'($urandom); amount = 4'($urandom);
    lat8 = -1; lat4 = -1;
    for (int e = 0; e < 40 && (lat8 < 0 || lat4 < 0); e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (lat8 < 0 && ov8 === 1'b1) lat8 = e;
      if (lat4 < 0 && ov4 === 1'b1) lat4 = e;
    end
    chk("lat8", 32'(lat8), n8);
    chk("lat4", 32'(lat4), n4);
    chk("res8", 32'(res8), e8);
    chk("res4", 32'(res4), e4);
    chk("busy8_done", 32'(bz8), 1);
    chk("ready8_done", 32'(ir8), 0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready8_idle", 32'(ir8), 1);
    chk("valid8_idle", 32'(ov8), 0);
    chk("ready4_idle", 32'(ir4), 1);
    chk("valid4_idle", 32'(ov4), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int unsigned n, e8;
    int waited;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operand = '0; mode = '0; amount = '0;
    #12;
    chk("rst_ready", 32'(ir8), 1);
    chk("rst_valid", 32'(ov8), 0);
    chk("rst_result", 32'(res8), 0);
    chk("rst_busy", 32'(bz8), 0);
    @(negedge clk); rst = 1'b0;

    // Directed cases from the plan.
    run_job(8'h06, 2'b00, 4'd2);
    run_job(8'h0E, 2'b01, 4'd3);
    run_job(8'hA5, 2'b01, 4'd9);
    run_job(8'hA5, 2'b00, 4'd0);
    run_job(8'hFF, 2'b10, 4'd12);
    run_job(8'h81, 2'b11, 4'd1);
    run_job(8'hFF, 2'b11, 4'd15);

    // Backpressure: result held, new request ignored while in DONE.
    e8 = model(8, 8'h5A, 0, 3, n);
    @(negedge clk);
    operand = 8'h5A; mode = 2'b00; amount = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    waited = 0;
    while (ov8 !== 1'b1 && waited < 40) begin @(posedge clk); #1; waited++; end
    chk("bp_reach_done", 32'(ov8), 1);
    @(negedge clk);
    operand = 8'hFF; mode = 2'b11; amount = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_result", 32'(res8), e8);
      chk("bp_valid", 32'(ov8), 1);
      chk("bp_ready", 32'(ir8), 0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ready", 32'(ir8), 1);
    chk("bp_rel_valid", 32'(ov8), 0);
    chk("bp_rel_busy", 32'(bz8), 0);
    out_ready = 1'b0;

    // Reset in the middle of a RUN.
    @(negedge clk);
    operand = 8'h3C; mode = 2'b01; amount = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 32'(bz8), 1);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_valid", 32'(ov8), 0);
    chk("mid_rst_result", 32'(res8), 0);
    chk("mid_rst_ready", 32'(ir8), 1);
    chk("mid_rst_busy", 32'(bz8), 0);
    @(negedge clk); rst = 1'b0;
    run_job(8'h01, 2'b01, 4'd3);

    // Random jobs.
    for (int j = 0; j < 40; j++)
      run_job(8'($urandom), 2'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
